// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths,
// PC index derivation and the clear-sequencer state encoding.
package regfile_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  // The top index of the address space is the PC and is never stored.
  function automatic int pc_idx(input int aw);
    return (1 << aw) - 1;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks clr_idx over every stored entry once,
// holding init_busy high until the last entry has been written.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing CLR_VAL into rf[clr_idx]; core must stall
// ST_RUN   | clear done; normal read/write traffic
module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  output logic          init_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_IDX = AW'(pc_idx(AW) - 1);

  rf_state_e     state;
  logic [AW-1:0] clr_idx;

  // Sequencer state, index counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clr_idx   <= '0;
      init_busy <= 1'b1;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == LAST_IDX) begin
        state     <= ST_RUN;
        init_busy <= 1'b0;
      end
    end
  end

  // The array must not be touched while reset is held.
  assign clr_we   = (state == ST_CLEAR) && !reset;
  assign clr_addr = clr_idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: three combinational read ports, two write
// ports (port B wins on an address collision), top index reads r15 and is
// never stored, and a clear sequencer runs after every reset.
// Optional same-cycle write-to-read forwarding: define REGFILE_MP_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int            DW      = DW_DEF,
  parameter int            AW      = AW_DEF,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [AW-1:0] ra3,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic [DW-1:0] rd3,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [DW-1:0] wd3,
  input  logic          we4,
  input  logic [AW-1:0] wa4,
  input  logic [DW-1:0] wd4,
  input  logic [DW-1:0] r15,
  output logic          init_busy
);

  localparam int            NENT   = pc_idx(AW);
  localparam logic [AW-1:0] PC_IDX = AW'(pc_idx(AW));

  logic [DW-1:0] rf [0:NENT-1];

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  rf_clear_seq #(.AW(AW)) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  logic wr_a, wr_b;
  assign wr_a = we3 && (wa3 != PC_IDX) && !init_busy;
  assign wr_b = we4 && (wa4 != PC_IDX) && !init_busy;

  // Array update: clear writes pre-empt both ports; port B is applied last
  // so it overrides port A when both target the same entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we) begin
        rf[clr_addr] <= CLR_VAL;
      end else begin
        if (wr_a) rf[wa3] <= wd3;
        if (wr_b) rf[wa4] <= wd4;
      end
    end
  end

  logic [2:0][AW-1:0] ra_v;
  logic [2:0][DW-1:0] rd_v;
  assign ra_v = {ra3, ra2, ra1};

  // Read muxing for all three ports: PC first, then clear masking, then
  // optional forwarding, then the stored value.
  always_comb begin
    rd_v = '0;
    for (int p = 0; p < 3; p++) begin
      if (ra_v[p] == PC_IDX) begin
        rd_v[p] = r15;
      end else if (init_busy) begin
        rd_v[p] = CLR_VAL;
`ifdef REGFILE_MP_BYPASS_EN
      end else if (we4 && (wa4 == ra_v[p])) begin
        rd_v[p] = wd4;
      end else if (we3 && (wa3 == ra_v[p])) begin
        rd_v[p] = wd3;
`endif
      end else begin
        rd_v[p] = rf[ra_v[p]];
      end
    end
  end

  assign rd1 = rd_v[0];
  assign rd2 = rd_v[1];
  assign rd3 = rd_v[2];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp with default parameters.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  ra1 = '0, ra2 = '0, ra3 = '0;
  logic [31:0] rd1, rd2, rd3;
  logic        we3 = 1'b0, we4 = 1'b0;
  logic [3:0]  wa3 = '0, wa4 = '0;
  logic [31:0] wd3 = '0, wd4 = '0;
  logic [31:0] r15 = 32'h0000_0108;
  logic        init_busy;

  regfile_mp dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .r15(r15), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 15 stored registers plus a count of entries cleared
  // so far since the last reset (15 means the clear is complete).
  logic [31:0] mem [15];
  int          cleared = 0;
  bit          model_valid = 1'b0;

  function automatic logic [31:0] mread(input logic [3:0] a);
    if (a == 4'd15) return r15;
    if (cleared < 15) return 32'h0;
    if (BYPASS && we4 && wa4 == a) return wd4;
    if (BYPASS && we3 && wa3 == a) return wd3;
    return mem[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cleared     = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (cleared < 15) begin
        mem[cleared] = 32'h0;
        cleared++;
      end else begin
        if (we3 && wa3 != 4'd15) mem[wa3] = wd3;
        if (we4 && wa4 != 4'd15) mem[wa4] = wd4;
      end
    end
  end

  // Compare every output on every cycle, mid-period.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("init_busy", {31'b0, init_busy}, {31'b0, cleared < 15});
      chk("rd1", rd1, mread(ra1));
      chk("rd2", rd2, mread(ra2));
      chk("rd3", rd3, mread(ra3));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles from now, bounded; returns the count.
  task automatic busy_window(output int n);
    n = 0;
    for (int i = 0; i < 40 && init_busy; i++) begin
      n++;
      cyc();
    end
  endtask

  task automatic write1(input logic [3:0] a, input logic [31:0] d);
    we3 = 1'b1; wa3 = a; wd3 = d;
    cyc();
    we3 = 1'b0;
  endtask

  logic [31:0] snap [15];
  int n;

  initial begin
    #1;
    // Reset for two cycles, then check the clear window and reads.
    reset = 1'b1; ra1 = 4'd3; ra2 = 4'd15; ra3 = 4'd0;
    cyc(); cyc();
    reset = 1'b0;
    chk("busy_after_reset", {31'b0, init_busy}, 32'd1);
    chk("rd1_r3_during_clear", rd1, 32'h0);
    chk("rd2_pc_during_clear", rd2, 32'h0000_0108);
    busy_window(n);
    chk("clear_window_len", n, 32'd15);
    chk("rd1_r3_after_clear", rd1, 32'h0);
    chk("rd2_pc_after_clear", rd2, 32'h0000_0108);

    // Single write to R5, same-cycle and next-cycle reads.
    ra1 = 4'd5; ra2 = 4'd5; ra3 = 4'd5;
    we3 = 1'b1; wa3 = 4'd5; wd3 = 32'hDEAD_BEEF;
    #1;
    chk("r5_same_cycle", rd1, BYPASS ? 32'hDEAD_BEEF : 32'h0);
    cyc();
    we3 = 1'b0;
    #1;
    chk("r5_rd1", rd1, 32'hDEAD_BEEF);
    chk("r5_rd2", rd2, 32'hDEAD_BEEF);
    chk("r5_rd3", rd3, 32'hDEAD_BEEF);

    // Collision on R7: port B wins. Then disjoint writes to R8/R9.
    we3 = 1'b1; wa3 = 4'd7; wd3 = 32'h1111_1111;
    we4 = 1'b1; wa4 = 4'd7; wd4 = 32'h2222_2222;
    cyc();
    wa3 = 4'd9; wd3 = 32'h9999_0009;
    wa4 = 4'd8; wd4 = 32'h8888_0008;
    cyc();
    we3 = 1'b0; we4 = 1'b0;
    ra1 = 4'd7; ra2 = 4'd8; ra3 = 4'd9;
    #1;
    chk("r7_port_b_wins", rd1, 32'h2222_2222);
    chk("r8_port_b", rd2, 32'h8888_0008);
    chk("r9_port_a", rd3, 32'h9999_0009);

    // PC write must be dropped: sweep before and after.
    for (int i = 0; i < 15; i++) begin
      ra1 = 4'(i); #1; snap[i] = mem[i];
      chk("sweep_before", rd1, snap[i]);
    end
    write1(4'd15, 32'hFFFF_FFFF);
    ra1 = 4'd15; r15 = 32'h0000_0208; #1;
    chk("pc_read_after_pc_write", rd1, 32'h0000_0208);
    for (int i = 0; i < 15; i++) begin
      ra1 = 4'(i); #1;
      chk("sweep_after", rd1, snap[i]);
    end

    // Write R4, reset, then re-reset on cycle 6 of the clear.
    write1(4'd4, 32'hA5A5_A5A5);
    ra1 = 4'd4; #1;
    chk("r4_written", rd1, 32'hA5A5_A5A5);
    reset = 1'b1; cyc(); reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("busy_mid_clear", {31'b0, init_busy}, 32'd1);
    reset = 1'b1; cyc(); reset = 1'b0;
    busy_window(n);
    chk("restart_window_len", n, 32'd15);
    chk("r4_cleared", rd1, 32'h0);

    // Writes attempted to R2 throughout a clear window are ignored.
    write1(4'd2, 32'h0BAD_0002);
    reset = 1'b1; cyc(); reset = 1'b0;
    we3 = 1'b1; wa3 = 4'd2; wd3 = 32'h1234_5678;
    busy_window(n);
    we3 = 1'b0;
    chk("busy_write_window_len", n, 32'd15);
    ra2 = 4'd2; #1;
    chk("r2_ignored_during_clear", rd2, 32'h0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      we3 = $urandom_range(0, 1); wa3 = 4'($urandom_range(0, 15)); wd3 = $urandom;
      we4 = $urandom_range(0, 1); wa4 = ($urandom_range(0, 2) == 0) ? wa3 : 4'($urandom_range(0, 15));
      wd4 = $urandom;
      ra1 = 4'($urandom_range(0, 15)); ra2 = ($urandom_range(0, 1) == 1) ? wa4 : 4'($urandom_range(0, 15));
      ra3 = ($urandom_range(0, 1) == 1) ? wa3 : 4'($urandom_range(0, 15));
      r15 = $urandom;
      cyc();
    end
    reset = 1'b0; we3 = 1'b0; we4 = 1'b0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
